// File: rtl/reg_alu_mc_unit.sv
// Multi-cycle register file + ALU + data memory unit: DECODE/EXEC/MEM/WB/FIN per started instruction.
// Optional `MUL_EN adds an iterative shift-add unsigned multiply (FuncCode 011000) in a MUL state.
module reg_alu_mc_unit #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int IMM_W   = 16,
  parameter int MADDR_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [5:0]         FuncCode,
  input  logic               RegDst,
  input  logic               ALUSrc,
  input  logic [1:0]         ALUOp,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic               MemToReg,
  input  logic               RegWrite,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               Zero,
  output logic [DATA_W-1:0]  ALUResult,
  output logic [DATA_W-1:0]  ReadData
);
  localparam int NUM_REGS = 1 << RADDR_W;
  localparam int MEM_D    = 1 << MADDR_W;

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MEM, WB, FIN
`ifdef MUL_EN
    , MUL
`endif
  } state_t;

  state_t state, nextState;

  logic [RADDR_W-1:0] rsL, rtL, rdL;
  logic [IMM_W-1:0]   immL;
  logic [5:0]         funcL;
  logic [1:0]         aluOpL;
  logic               regDstL, aluSrcL, memWriteL, memReadL, memToRegL, regWriteL;
  logic [DATA_W-1:0]  opA, opB, storeData;
  logic               illegalFlag;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  mem  [MEM_D];

  logic [DATA_W-1:0]  aluRes, wbData, immExt;
  logic               aluIllegal;
  logic [RADDR_W-1:0] wbDest;
  logic [MADDR_W-1:0] memAddr;

`ifdef MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic              isMul;
  logic [DATA_W-1:0] mcand, mplier, product, mulSum;
  logic [CNT_W-1:0]  mulCnt;
  assign mulSum = product + (mplier[0] ? mcand : '0);
`endif

  assign immExt  = {{(DATA_W-IMM_W){immL[IMM_W-1]}}, immL};
  assign wbDest  = regDstL ? rdL : rtL;
  assign wbData  = memToRegL ? ReadData : ALUResult;
  assign memAddr = ALUResult[MADDR_W+1:2];

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign illegal = done & illegalFlag;

  always_comb begin
    aluRes     = '0;
    aluIllegal = 1'b0;
`ifdef MUL_EN
    isMul      = 1'b0;
`endif
    case (aluOpL)
      2'b01: aluRes = opA - opB;
      2'b10: begin
        case (funcL)
          6'b100000: aluRes = opA + opB;
          6'b100010: aluRes = opA - opB;
          6'b100100: aluRes = opA & opB;
          6'b100101: aluRes = opA | opB;
          6'b101010: aluRes = DATA_W'($signed(opA) < $signed(opB));
`ifdef MUL_EN
          6'b011000: isMul = 1'b1;
`endif
          default:   aluIllegal = 1'b1;
        endcase
      end
      default: aluRes = opA + opB;
    endcase
  end

  // Routing after the ALU result is final (EXEC, or end of MUL).
  function automatic state_t postExec(input logic memOp, input logic regWr, input logic ill);
    if (memOp)             return MEM;
    else if (regWr && !ill) return WB;
    else                   return FIN;
  endfunction

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (start) nextState = DECODE;
      DECODE: nextState = EXEC;
      EXEC: begin
`ifdef MUL_EN
        if (isMul) nextState = MUL; else
`endif
        nextState = postExec(memReadL | memWriteL, regWriteL, aluIllegal);
      end
`ifdef MUL_EN
      MUL:    if (mulCnt == '0) nextState = postExec(memReadL | memWriteL, regWriteL, 1'b0);
`endif
      MEM:    nextState = (regWriteL && !illegalFlag) ? WB : FIN;
      WB:     nextState = FIN;
      FIN:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nextState;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {rsL, rtL, rdL, immL, funcL, aluOpL} <= '0;
      {regDstL, aluSrcL, memWriteL, memReadL, memToRegL, regWriteL} <= '0;
      opA <= '0; opB <= '0; storeData <= '0;
      illegalFlag <= 1'b0; Zero <= 1'b0;
      ALUResult <= '0; ReadData <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef MUL_EN
      mcand <= '0; mplier <= '0; product <= '0; mulCnt <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        rsL <= rs; rtL <= rt; rdL <= rd; immL <= immediate; funcL <= FuncCode; aluOpL <= ALUOp;
        regDstL <= RegDst; aluSrcL <= ALUSrc; memWriteL <= MemWrite;
        memReadL <= MemRead; memToRegL <= MemToReg; regWriteL <= RegWrite;
      end
      if (state == DECODE) begin
        opA       <= regs[rsL];
        opB       <= aluSrcL ? immExt : regs[rtL];
        storeData <= regs[rtL];
      end
      if (state == EXEC) begin
        ALUResult   <= aluRes;
        Zero        <= (aluRes == '0);
        illegalFlag <= aluIllegal;
`ifdef MUL_EN
        mcand   <= opA;
        mplier  <= opB;
        product <= '0;
        mulCnt  <= CNT_W'(DATA_W-1);
`endif
      end
`ifdef MUL_EN
      if (state == MUL) begin
        product <= mulSum;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mulCnt  <= mulCnt - CNT_W'(1);
        if (mulCnt == '0) begin
          ALUResult <= mulSum;
          Zero      <= (mulSum == '0);
        end
      end
`endif
      // A store takes priority, so a combined read/write leaves ReadData untouched.
      if (state == MEM && memReadL && !memWriteL) ReadData <= mem[memAddr];
      if (state == WB && wbDest != '0) regs[wbDest] <= wbData;
    end
  end

  // Memory is deliberately not reset; reset forces IDLE so an aborted store never lands.
  always_ff @(posedge clock)
    if (state == MEM && memWriteL) mem[memAddr] <= storeData;

endmodule

// File: tb/tb_reg_alu_mc_unit.sv
// Self-checking bench for reg_alu_mc_unit: directed scenarios plus random instructions
// checked against an instruction-level reference model (register/memory arrays).
module tb_reg_alu_mc_unit;
  logic        clock, reset, start;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [5:0]  FuncCode;
  logic        RegDst, ALUSrc, MemWrite, MemRead, MemToReg, RegWrite;
  logic [1:0]  ALUOp;
  logic        busy, done, illegal, Zero;
  logic [31:0] ALUResult, ReadData;

  int checks = 0;
  int failures = 0;

  logic [31:0] mR [32];
  logic [31:0] mM [64];
  logic [31:0] mRD;

  reg_alu_mc_unit dut (
    .clock(clock), .reset(reset), .start(start), .rs(rs), .rt(rt), .rd(rd),
    .immediate(immediate), .FuncCode(FuncCode), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .busy(busy), .done(done), .illegal(illegal), .Zero(Zero),
    .ALUResult(ALUResult), .ReadData(ReadData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); immediate = 16'($urandom);
    FuncCode = 6'($urandom); ALUOp = 2'($urandom);
    {RegDst, ALUSrc, MemWrite, MemRead, MemToReg, RegWrite} = 6'($urandom);
  endtask

  // Runs one instruction; the model is evaluated first from the current architectural state.
  task automatic run(input string tag, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic [15:0] imm, input logic [5:0] fn, input logic [1:0] op,
                     input logic dst, input logic src, input logic mw, input logic mr,
                     input logic m2r, input logic rw, input bit hold = 0);
    logic [31:0] a, b, res, rdNew;
    logic        ill;
    logic [4:0]  dest;
    int          lat, cyc;
    a = mR[s];
    b = src ? {{16{imm[15]}}, imm} : mR[t];
    ill = 1'b0;
    lat = 3;
    case (op)
      2'b01: res = a - b;
      2'b10: case (fn)
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MUL_EN
        6'h18: begin res = a * b; lat += 32; end
`endif
        default: begin res = 32'd0; ill = 1'b1; end
      endcase
      default: res = a + b;
    endcase
    rdNew = mRD;
    if (mw | mr) lat++;
    if (mw) mM[res[7:2]] = mR[t];
    else if (mr) rdNew = mM[res[7:2]];
    if (rw && !ill) begin
      lat++;
      dest = dst ? d : t;
      if (dest != 5'd0) mR[dest] = m2r ? rdNew : res;
    end
    mRD = rdNew;

    @(negedge clock);
    rs = s; rt = t; rd = d; immediate = imm; FuncCode = fn; ALUOp = op;
    RegDst = dst; ALUSrc = src; MemWrite = mw; MemRead = mr; MemToReg = m2r; RegWrite = rw;
    start = 1'b1;
    @(posedge clock); #1;
    cyc = 1;
    if (!hold) start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    scramble();
    while (!done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
    chk({tag, ".ALUResult"}, ALUResult, res);
    chk({tag, ".Zero"}, 32'(Zero), 32'(res == 32'd0));
    chk({tag, ".ReadData"}, ReadData, rdNew);
    @(posedge clock); #1;
    if (hold) begin
      chk({tag, ".finStartIgnored"}, 32'({busy, done}), 32'd0);
      start = 1'b0;
    end
  endtask

  // Reads R[n] through the ALU (add R[n] + R0, no writeback, branch-like latency).
  task automatic readReg(input string tag, input logic [4:0] n);
    run(tag, n, 5'd0, 5'd0, 16'h0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0] fns [8];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h18, 6'h3f};
    for (int i = 0; i < 32; i++) mR[i] = 32'd0;
    for (int i = 0; i < 64; i++) mM[i] = 32'd0;
    mRD = 32'd0;
    reset = 1'b1; start = 1'b0;
    scramble();
    #12;
    chk("reset.flags", 32'({busy, done, illegal, Zero}), 32'd0);
    chk("reset.ALUResult", ALUResult, 32'd0);
    chk("reset.ReadData", ReadData, 32'd0);
    @(negedge clock); reset = 1'b0;

    run("addi", 5'd0, 5'd5, 5'd0, 16'h0014, 6'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run("subR0", 5'd5, 5'd5, 5'd0, 16'h0, 6'h22, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    readReg("readR0", 5'd0);
    run("subR3", 5'd5, 5'd5, 5'd3, 16'h0, 6'h22, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("sw", 5'd0, 5'd5, 5'd0, 16'h0008, 6'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("lw", 5'd0, 5'd7, 5'd0, 16'h0008, 6'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    readReg("readR7", 5'd7);
    run("illegal", 5'd5, 5'd5, 5'd5, 16'h0, 6'h00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    readReg("readR5", 5'd5);
    run("beqLike", 5'd5, 5'd7, 5'd0, 16'h0, 6'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("sltNeg", 5'd0, 5'd4, 5'd6, 16'h8000, 6'h2a, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run("startHeld", 5'd5, 5'd7, 5'd8, 16'h0, 6'h2a, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    for (int i = 1; i < 32; i++)
      run("initReg", 5'd0, 5'(i), 5'd0, 16'($urandom), 6'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++)
      run("fillMem", 5'd0, 5'($urandom), 5'd0, 16'(i * 4), 6'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic mw, mr;
      mw = ($urandom_range(0, 3) == 0);
      mr = ($urandom_range(0, 3) == 0);
      run("rand", 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), fns[$urandom_range(0, 7)],
          2'($urandom), 1'($urandom), 1'($urandom), mw, mr, 1'($urandom), 1'($urandom));
    end

    // Abort an add to R9 while it is in EXEC.
    @(negedge clock);
    rs = 5'd0; rt = 5'd9; immediate = 16'h0055; ALUOp = 2'b00; ALUSrc = 1'b1;
    RegDst = 1'b0; RegWrite = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; MemToReg = 1'b0;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; #1;
    chk("abort.busy", 32'({busy, done}), 32'd0);
    chk("abort.ALUResult", ALUResult, 32'd0);
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 32; i++) mR[i] = 32'd0;
    mRD = 32'd0;
    repeat (3) @(posedge clock);
    #1 chk("abort.idle", 32'(busy), 32'd0);
    readReg("readR9", 5'd9);
    for (int i = 0; i < 20; i++)
      run("postReset", 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), fns[$urandom_range(0, 7)],
          2'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
